// File: rtl/inst_rom_pkg.sv
// Shared FSM state encoding and image framing constants for inst_rom_loader.
// Defining INST_ROM_CHKSUM_EN adds the CSUM state (trailing 4-byte image checksum).
`ifndef RegBus
`define RegBus 31:0
`endif

package inst_rom_pkg;

   localparam int HDR_BYTES  = 2;
   localparam int WORD_BYTES = 4;
   localparam int IDX_W      = $clog2(WORD_BYTES);

   typedef enum logic [2:0] {
      ST_HDR0,
      ST_HDR1,
      ST_DATA,
`ifdef INST_ROM_CHKSUM_EN
      ST_CSUM,
`endif
      ST_RUN,
      ST_ERR
   } state_t;

endpackage

// File: rtl/inst_rom_loader_byte_packer.sv
// byte_packer: assembles big-endian 32-bit words from accepted load bytes.
// Shared by the data and checksum phases of inst_rom_loader.
module byte_packer
   import inst_rom_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   input  logic           accept,
   input  logic [7:0]     data,
   output logic           word_vld,
   output logic [`RegBus] word
);

   logic [IDX_W-1:0]            idx_q;
   logic [8*(WORD_BYTES-1)-1:0] shift_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx_q <= '0;
      end else if (accept) begin
         idx_q <= idx_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         shift_q <= {shift_q[8*(WORD_BYTES-2)-1:0], data};
      end
   end

   // The final byte bypasses the shift register so the word is ready on its accepting edge.
   assign word_vld = accept && (idx_q == IDX_W'(WORD_BYTES - 1));
   assign word     = {shift_q, data};

endmodule

// File: rtl/inst_rom_loader.sv
// inst_rom_loader: boot-time instruction ROM loaded over a byte stream, holds the core in reset until loaded.
// Optional INST_ROM_CHKSUM_EN: verify a trailing 32-bit sum of all data words before releasing the core.
module inst_rom_loader
   import inst_rom_pkg::*;
#(
   parameter int DEPTH_LOG2 = 10
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           ld_valid_i,
   input  logic [7:0]     ld_data_i,
   output logic           ld_ready_o,
   input  logic           rom_ce_i,
   input  logic [31:0]    rom_addr_i,
   output logic [`RegBus] rom_data_o,
   output logic           cpu_rst_o,
   output logic           ld_done_o,
   output logic           ld_err_o
);

   localparam int CNT_W = 8*HDR_BYTES + 1;
   localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(1) << DEPTH_LOG2;
`ifdef INST_ROM_CHKSUM_EN
   localparam state_t ST_POST = ST_CSUM;
`else
   localparam state_t ST_POST = ST_RUN;
`endif

   state_t           state_q, state_d;
   logic [7:0]       cnt_hi_q;
   logic [CNT_W-1:0] n_words_q;
   logic [CNT_W-1:0] waddr_q;
   logic [CNT_W-1:0] n_hdr;
   logic             acc, pk_accept, we, word_vld;
   logic [`RegBus]   word;
   logic [`RegBus]   mem [2**DEPTH_LOG2];
`ifdef INST_ROM_CHKSUM_EN
   logic [`RegBus]   sum_q;
`endif

   // Only the index bits select a word; byte offset and high bits wrap.
   logic unused_addr;
   assign unused_addr = ^{rom_addr_i[31:DEPTH_LOG2+2], rom_addr_i[1:0]};

   assign acc   = ld_valid_i && ld_ready_o;
   assign n_hdr = {1'b0, cnt_hi_q, ld_data_i};
`ifdef INST_ROM_CHKSUM_EN
   assign pk_accept = acc && (state_q == ST_DATA || state_q == ST_CSUM);
`else
   assign pk_accept = acc && (state_q == ST_DATA);
`endif
   assign we = word_vld && (state_q == ST_DATA);

   byte_packer u_packer (
      .clk      (clk),
      .rst      (rst),
      .accept   (pk_accept),
      .data     (ld_data_i),
      .word_vld (word_vld),
      .word     (word)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_HDR0;
         cnt_hi_q  <= '0;
         n_words_q <= '0;
         waddr_q   <= '0;
`ifdef INST_ROM_CHKSUM_EN
         sum_q     <= '0;
`endif
      end else begin
         state_q <= state_d;
         if (acc && state_q == ST_HDR0) cnt_hi_q  <= ld_data_i;
         if (acc && state_q == ST_HDR1) n_words_q <= n_hdr;
         if (we) begin
            waddr_q <= waddr_q + CNT_W'(1);
`ifdef INST_ROM_CHKSUM_EN
            sum_q   <= sum_q + word;
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (we) mem[waddr_q[DEPTH_LOG2-1:0]] <= word;
   end

   always_comb begin
      state_d    = state_q;
      ld_ready_o = 1'b1;
      cpu_rst_o  = 1'b1;
      ld_done_o  = 1'b0;
      ld_err_o   = 1'b0;
      case (state_q)
         ST_HDR0: if (acc) state_d = ST_HDR1;
         ST_HDR1: begin
            if (acc) begin
               if (n_hdr > MAX_WORDS)  state_d = ST_ERR;
               else if (n_hdr == '0)   state_d = ST_POST;
               else                    state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (we && (waddr_q + CNT_W'(1)) == n_words_q) state_d = ST_POST;
         end
`ifdef INST_ROM_CHKSUM_EN
         ST_CSUM: if (word_vld) state_d = (word == sum_q) ? ST_RUN : ST_ERR;
`endif
         ST_RUN: begin
            ld_ready_o = 1'b0;
            cpu_rst_o  = 1'b0;
            ld_done_o  = 1'b1;
         end
         ST_ERR: begin
            ld_ready_o = 1'b0;
            ld_err_o   = 1'b1;
         end
         default: state_d = ST_HDR0;
      endcase
   end

   assign rom_data_o = (rom_ce_i && state_q == ST_RUN) ? mem[rom_addr_i[DEPTH_LOG2+1:2]] : '0;

endmodule
